// File: rtl/memory_map_arbiter.sv
// Round-robin arbiter sharing the memory-map register port between the
// flight-computer SPI slave (requester 0) and the UART debug port (requester 1).
module memory_map_arbiter #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic              clk210_p,
  input  logic              reset_n_p,
  input  logic              spi_req_p,
  input  logic              spi_we_p,
  input  logic [ADDR_W-1:0] spi_addr_p,
  input  logic [DATA_W-1:0] spi_wdata_p,
  output logic [DATA_W-1:0] spi_rdata_p,
  output logic              spi_done_p,
  input  logic              uart_req_p,
  input  logic              uart_we_p,
  input  logic [ADDR_W-1:0] uart_addr_p,
  input  logic [DATA_W-1:0] uart_wdata_p,
  output logic [DATA_W-1:0] uart_rdata_p,
  output logic              uart_done_p,
  output logic              mm_wr_en_p,
  output logic [ADDR_W-1:0] mm_wr_addr_p,
  output logic [DATA_W-1:0] mm_wr_data_p,
  output logic              mm_rd_en_p,
  output logic [ADDR_W-1:0] mm_rd_addr_p,
  input  logic [DATA_W-1:0] mm_rd_data_p,
  output logic              busy_p,
  output logic [15:0]       txn_count_p
);

  localparam int unsigned CNT_W = 3;
  localparam int unsigned TXN_W = 16;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RD_LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic               rst_sync_q;
  logic               last_uart_q;
  logic               owner_uart_q;
  logic               we_q;
  logic [CNT_W-1:0]   wait_cnt_q;

  logic               grant_uart_c;
  logic               start_c;
  logic               sel_we_c;
  logic [ADDR_W-1:0]  sel_addr_c;
  logic [DATA_W-1:0]  sel_wdata_c;

  logic               wr_en_d;
  logic               rd_en_d;
  logic               busy_d;
  logic               finish_d;
  logic               capture_d;
  logic               spi_done_d;
  logic               uart_done_d;

  // Reset release: requests are honoured from the second edge after deassertion
  always_ff @(posedge clk210_p or negedge reset_n_p) begin
    if (!reset_n_p) rst_sync_q <= 1'b0;
    else            rst_sync_q <= 1'b1;
  end

  // Arbitration: a lone requester wins; on a tie the one not served last wins
  always_comb begin
    grant_uart_c = uart_req_p && (!spi_req_p || !last_uart_q);
    start_c      = (state_q == ST_IDLE) && rst_sync_q && (spi_req_p || uart_req_p);
    sel_we_c     = grant_uart_c ? uart_we_p    : spi_we_p;
    sel_addr_c   = grant_uart_c ? uart_addr_p  : spi_addr_p;
    sel_wdata_c  = grant_uart_c ? uart_wdata_p : spi_wdata_p;
  end

  // State register
  always_ff @(posedge clk210_p or negedge reset_n_p) begin
    if (!reset_n_p) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_c) state_d = ST_ISSUE;
      ST_ISSUE: state_d = we_q ? ST_DONE : ST_WAIT;
      ST_WAIT:  if (wait_cnt_q == WAIT_LAST) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output decode: next values of the registered outputs
  always_comb begin
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    capture_d = 1'b0;
    busy_d    = (state_d != ST_IDLE);
    finish_d  = (state_d == ST_DONE);
    case (state_q)
      ST_IDLE: begin
        wr_en_d = start_c && sel_we_c;
        rd_en_d = start_c && !sel_we_c;
      end
      ST_ISSUE: rd_en_d = !we_q;
      ST_WAIT: begin
        // strobe must stay up until the data is taken, else the map returns filler
        rd_en_d   = (state_d == ST_WAIT);
        capture_d = (state_d == ST_DONE);
      end
      default: ;
    endcase
    spi_done_d  = finish_d && !owner_uart_q;
    uart_done_d = finish_d && owner_uart_q;
  end

  // Transaction context: direction, owner, read wait counter, fairness flag
  always_ff @(posedge clk210_p or negedge reset_n_p) begin
    if (!reset_n_p) begin
      we_q         <= 1'b0;
      owner_uart_q <= 1'b0;
      last_uart_q  <= 1'b1;
      wait_cnt_q   <= '0;
    end else begin
      if (start_c) begin
        we_q         <= sel_we_c;
        owner_uart_q <= grant_uart_c;
      end
      if (state_q == ST_ISSUE)     wait_cnt_q <= '0;
      else if (state_q == ST_WAIT) wait_cnt_q <= wait_cnt_q + CNT_W'(1);
      if (finish_d) last_uart_q <= owner_uart_q;
    end
  end

  // Registered outputs
  always_ff @(posedge clk210_p or negedge reset_n_p) begin
    if (!reset_n_p) begin
      mm_wr_en_p   <= 1'b0;
      mm_rd_en_p   <= 1'b0;
      mm_wr_addr_p <= '0;
      mm_rd_addr_p <= '0;
      mm_wr_data_p <= '0;
      spi_rdata_p  <= '0;
      uart_rdata_p <= '0;
      spi_done_p   <= 1'b0;
      uart_done_p  <= 1'b0;
      busy_p       <= 1'b0;
      txn_count_p  <= '0;
    end else begin
      mm_wr_en_p  <= wr_en_d;
      mm_rd_en_p  <= rd_en_d;
      busy_p      <= busy_d;
      spi_done_p  <= spi_done_d;
      uart_done_p <= uart_done_d;
      if (start_c) begin
        mm_wr_addr_p <= sel_addr_c;
        mm_rd_addr_p <= sel_addr_c;
        if (sel_we_c) mm_wr_data_p <= sel_wdata_c;
      end
      if (capture_d) begin
        if (owner_uart_q) uart_rdata_p <= mm_rd_data_p;
        else              spi_rdata_p  <= mm_rd_data_p;
      end
      if (finish_d) txn_count_p <= txn_count_p + TXN_W'(1);
    end
  end

endmodule

// File: tb/tb_memory_map_arbiter.sv
// Bench for memory_map_arbiter: directed vector table, corner sequences and
// a randomized run against a transaction-level reference model.
module tb_memory_map_arbiter;

  localparam int RDL = 1;

  logic        clk;
  logic        rst_n;
  logic        spi_req, spi_we, uart_req, uart_we;
  logic [15:0] spi_addr, spi_wdata, uart_addr, uart_wdata;
  logic [15:0] spi_rdata, uart_rdata;
  logic        spi_done, uart_done;
  logic        mm_wr_en, mm_rd_en, busy;
  logic [15:0] mm_wr_addr, mm_wr_data, mm_rd_addr, mm_rd_data, txn_count;

  // second instance with a 3-cycle read latency, SPI side only
  logic        s3_req, s3_we, u3_req, u3_we;
  logic [15:0] s3_addr, s3_wdata, u3_addr, u3_wdata;
  logic [15:0] s3_rdata, u3_rdata;
  logic        s3_done, u3_done;
  logic        wr_en3, rd_en3, busy3;
  logic [15:0] wr_addr3, wr_data3, rd_addr3, rd_data3, cnt3, rd3_run;

  int n_tests = 0;
  int n_fail  = 0;

  memory_map_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LATENCY(RDL)) dut (
    .clk210_p(clk), .reset_n_p(rst_n),
    .spi_req_p(spi_req), .spi_we_p(spi_we), .spi_addr_p(spi_addr), .spi_wdata_p(spi_wdata),
    .spi_rdata_p(spi_rdata), .spi_done_p(spi_done),
    .uart_req_p(uart_req), .uart_we_p(uart_we), .uart_addr_p(uart_addr), .uart_wdata_p(uart_wdata),
    .uart_rdata_p(uart_rdata), .uart_done_p(uart_done),
    .mm_wr_en_p(mm_wr_en), .mm_wr_addr_p(mm_wr_addr), .mm_wr_data_p(mm_wr_data),
    .mm_rd_en_p(mm_rd_en), .mm_rd_addr_p(mm_rd_addr), .mm_rd_data_p(mm_rd_data),
    .busy_p(busy), .txn_count_p(txn_count)
  );

  memory_map_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LATENCY(3)) dut3 (
    .clk210_p(clk), .reset_n_p(rst_n),
    .spi_req_p(s3_req), .spi_we_p(s3_we), .spi_addr_p(s3_addr), .spi_wdata_p(s3_wdata),
    .spi_rdata_p(s3_rdata), .spi_done_p(s3_done),
    .uart_req_p(u3_req), .uart_we_p(u3_we), .uart_addr_p(u3_addr), .uart_wdata_p(u3_wdata),
    .uart_rdata_p(u3_rdata), .uart_done_p(u3_done),
    .mm_wr_en_p(wr_en3), .mm_wr_addr_p(wr_addr3), .mm_wr_data_p(wr_data3),
    .mm_rd_en_p(rd_en3), .mm_rd_addr_p(rd_addr3), .mm_rd_data_p(rd_data3),
    .busy_p(busy3), .txn_count_p(cnt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory-map model: registered read data, filler whenever the strobe is low
  logic [15:0] mem_q  [0:255];
  bit          mem_wr [0:255];

  function automatic logic [15:0] init_val(input logic [7:0] a);
    if (a == 8'h03) return 16'hBEEF;
    return {8'hC3, a};
  endfunction

  function automatic logic [15:0] mem_rd(input logic [7:0] a);
    return mem_wr[a] ? mem_q[a] : init_val(a);
  endfunction

  always @(posedge clk) begin
    if (mm_wr_en === 1'b1) begin
      mem_q[mm_wr_addr[7:0]]  <= mm_wr_data;
      mem_wr[mm_wr_addr[7:0]] <= 1'b1;
    end
    mm_rd_data <= (mm_rd_en === 1'b1) ? mem_rd(mm_rd_addr[7:0]) : 16'hDEAD;
  end

  // Latency-3 map: returns A000 + number of strobe cycles seen so far
  always @(posedge clk) begin
    if (rd_en3 === 1'b1) begin
      rd3_run  <= rd3_run + 16'd1;
      rd_data3 <= 16'hA000 + rd3_run + 16'd1;
    end else begin
      rd3_run  <= 16'd0;
      rd_data3 <= 16'hDEAD;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_all();
    spi_req = 1'b0; uart_req = 1'b0; s3_req = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drop_all();
    #1;
    chk("reset_outputs_nonzero_bits",
        $countones({spi_rdata, spi_done, uart_rdata, uart_done, mm_wr_en, mm_wr_addr,
                    mm_wr_data, mm_rd_en, mm_rd_addr, busy, txn_count}), 0);
    chk("reset3_outputs_nonzero_bits",
        $countones({s3_rdata, s3_done, u3_rdata, u3_done, wr_en3, wr_addr3,
                    wr_data3, rd_en3, rd_addr3, busy3, cnt3}), 0);
    step(); step();
    rst_n = 1'b1;
    step(); step();
  endtask

  // One isolated transaction through the L=1 instance, cycle by cycle
  task automatic run_single(input bit uart, input bit we, input logic [15:0] addr,
                            input logic [15:0] wdata, input logic [15:0] exp_rd,
                            input logic [15:0] exp_cnt);
    if (uart) begin
      uart_req = 1'b1; uart_we = we; uart_addr = addr; uart_wdata = wdata;
    end else begin
      spi_req = 1'b1; spi_we = we; spi_addr = addr; spi_wdata = wdata;
    end
    step();
    chk("issue_busy", busy, 1);
    chk("issue_wr_en", mm_wr_en, we);
    chk("issue_rd_en", mm_rd_en, !we);
    if (we) begin
      chk("issue_wr_addr", mm_wr_addr, addr);
      chk("issue_wr_data", mm_wr_data, wdata);
    end else begin
      chk("issue_rd_addr", mm_rd_addr, addr);
      step();
      chk("wait_rd_en", mm_rd_en, 1);
      chk("wait_dones", {spi_done, uart_done}, 0);
    end
    step();
    chk("done_own", uart ? uart_done : spi_done, 1);
    chk("done_other", uart ? spi_done : uart_done, 0);
    chk("done_strobes", {mm_wr_en, mm_rd_en}, 0);
    chk("done_count", txn_count, exp_cnt);
    if (!we) chk("done_rdata", uart ? uart_rdata : spi_rdata, exp_rd);
    step();
    drop_all();
    chk("idle_busy", busy, 0);
    chk("idle_dones", {spi_done, uart_done}, 0);
  endtask

  typedef struct {
    bit          uart;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t vecs [6];

  // Reference model state for the randomized run
  bit          r_req [2], r_we [2], p_req [2], p_we [2], done_last [2], done_now [2];
  logic [15:0] r_addr [2], r_wd [2], p_addr [2], p_wd [2];
  bit          sh_wr [0:255];
  logic [15:0] sh_val [0:255];
  bit          m_busy, m_owner, m_we, m_last_uart, m_prev_idle;
  bit          e_wr, e_rd, e_done;
  logic [15:0] m_addr, m_wd, m_rdval, m_cnt;
  logic [15:0] m_rdata [2];
  int          m_issue, m_off;
  int          n_done;
  int          order [4];

  initial begin
    rst_n = 1'b1;
    spi_req = 0; spi_we = 0; spi_addr = 0; spi_wdata = 0;
    uart_req = 0; uart_we = 0; uart_addr = 0; uart_wdata = 0;
    s3_req = 0; s3_we = 0; s3_addr = 0; s3_wdata = 0;
    u3_req = 0; u3_we = 0; u3_addr = 0; u3_wdata = 0;
    rd3_run = 0;

    vecs[0] = '{uart: 1'b0, we: 1'b1, addr: 16'h0053, wdata: 16'h0001, exp_rd: 16'h0000};
    vecs[1] = '{uart: 1'b1, we: 1'b0, addr: 16'h0003, wdata: 16'h0000, exp_rd: 16'hBEEF};
    vecs[2] = '{uart: 1'b0, we: 1'b0, addr: 16'h0053, wdata: 16'h0000, exp_rd: 16'h0001};
    vecs[3] = '{uart: 1'b1, we: 1'b1, addr: 16'h0010, wdata: 16'hABCD, exp_rd: 16'h0000};
    vecs[4] = '{uart: 1'b0, we: 1'b0, addr: 16'h0010, wdata: 16'h0000, exp_rd: 16'hABCD};
    vecs[5] = '{uart: 1'b1, we: 1'b0, addr: 16'h0053, wdata: 16'h0000, exp_rd: 16'h0001};

    #2;
    do_reset();

    // Reset release: the first edge after deassertion must not sample
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    spi_req = 1'b1; spi_we = 1'b1; spi_addr = 16'h0055; spi_wdata = 16'h1234;
    step();
    chk("sync_edge1_busy", busy, 0);
    step();
    chk("sync_edge2_busy", busy, 1);
    chk("sync_edge2_wr_en", mm_wr_en, 1);
    step();
    chk("sync_done", spi_done, 1);
    step();
    drop_all();

    // Directed vector table
    do_reset();
    for (int i = 0; i < 6; i++)
      run_single(vecs[i].uart, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                 vecs[i].exp_rd, 16'(i + 1));

    // Both requesters reading continuously: grants must alternate
    do_reset();
    spi_req = 1'b1; spi_we = 1'b0; spi_addr = 16'h0020;
    uart_req = 1'b1; uart_we = 1'b0; uart_addr = 16'h0021;
    n_done = 0;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (spi_done === 1'b1 && uart_done === 1'b1) chk("alt_both_done", 1, 0);
      if ((spi_done === 1'b1 || uart_done === 1'b1) && n_done < 4) begin
        order[n_done] = (uart_done === 1'b1) ? 1 : 0;
        n_done++;
      end
    end
    drop_all();
    chk("alt_done_count", n_done, 4);
    for (int k = 0; k < 4; k++) chk("alt_grant_order", (k < n_done) ? order[k] : 9, k % 2);
    chk("alt_txn_count", txn_count, 4);
    chk("alt_spi_rdata", spi_rdata, 16'hC320);
    chk("alt_uart_rdata", uart_rdata, 16'hC321);

    // RD_LATENCY = 3 read on the second instance
    do_reset();
    s3_req = 1'b1; s3_we = 1'b0; s3_addr = 16'h0040;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("l3_rd_en_high", rd_en3, 1);
      chk("l3_early_done", s3_done, 0);
    end
    step();
    chk("l3_rd_en_low", rd_en3, 0);
    chk("l3_done", s3_done, 1);
    chk("l3_rdata", s3_rdata, 16'hA003);
    chk("l3_count", cnt3, 1);
    step();
    drop_all();

    // Reset asserted in the WAIT state of a read
    do_reset();
    run_single(1'b1, 1'b0, 16'h0021, 16'h0000, 16'hC321, 16'd1);
    uart_req = 1'b1; uart_we = 1'b0; uart_addr = 16'h0003;
    step();
    step();
    chk("midrst_in_wait", mm_rd_en, 1);
    #1;
    rst_n = 1'b0;
    drop_all();
    #1;
    chk("midrst_outputs_nonzero_bits",
        $countones({spi_rdata, spi_done, uart_rdata, uart_done, mm_wr_en, mm_wr_addr,
                    mm_wr_data, mm_rd_en, mm_rd_addr, busy, txn_count}), 0);
    step();
    chk("midrst_no_done", {spi_done, uart_done, busy}, 0);
    rst_n = 1'b1;
    step();
    chk("midrst_release_no_done", {spi_done, uart_done, busy}, 0);
    step();
    chk("midrst_release2_no_done", {spi_done, uart_done, busy}, 0);
    run_single(1'b0, 1'b1, 16'h0056, 16'h7777, 16'h0000, 16'd1);

    // Randomized traffic against the transaction-level model
    do_reset();
    m_busy = 0; m_owner = 0; m_we = 0; m_last_uart = 1; m_prev_idle = 1;
    m_cnt = 0; m_rdata[0] = 0; m_rdata[1] = 0; m_issue = 0;
    for (int r = 0; r < 2; r++) begin
      r_req[r] = 0; r_we[r] = 0; r_addr[r] = 0; r_wd[r] = 0;
      p_req[r] = 0; p_we[r] = 0; p_addr[r] = 0; p_wd[r] = 0;
      done_last[r] = 0; done_now[r] = 0;
    end
    for (int cyc = 0; cyc < 2000; cyc++) begin
      step();
      if (!m_busy && m_prev_idle && (p_req[0] || p_req[1])) begin
        m_owner = (p_req[0] && p_req[1]) ? !m_last_uart : p_req[1];
        m_busy  = 1'b1;
        m_we    = p_we[m_owner];
        m_addr  = p_addr[m_owner];
        m_wd    = p_wd[m_owner];
        m_issue = cyc;
        if (m_we) begin
          sh_wr[m_addr[7:0]]  = 1'b1;
          sh_val[m_addr[7:0]] = m_wd;
        end else begin
          m_rdval = sh_wr[m_addr[7:0]] ? sh_val[m_addr[7:0]] : init_val(m_addr[7:0]);
        end
      end
      m_off  = cyc - m_issue;
      e_wr   = m_busy && m_we && (m_off == 0);
      e_rd   = m_busy && !m_we && (m_off <= RDL);
      e_done = m_busy && (m_off == (m_we ? 1 : 1 + RDL));
      if (e_done) begin
        m_cnt       = m_cnt + 16'd1;
        m_last_uart = m_owner;
        if (!m_we) m_rdata[m_owner] = m_rdval;
      end
      chk("rnd_busy", busy, m_busy);
      chk("rnd_wr_en", mm_wr_en, e_wr);
      chk("rnd_rd_en", mm_rd_en, e_rd);
      chk("rnd_spi_done", spi_done, e_done && !m_owner);
      chk("rnd_uart_done", uart_done, e_done && m_owner);
      chk("rnd_spi_rdata", spi_rdata, m_rdata[0]);
      chk("rnd_uart_rdata", uart_rdata, m_rdata[1]);
      chk("rnd_txn_count", txn_count, m_cnt);
      if (e_wr) begin
        chk("rnd_wr_addr", mm_wr_addr, m_addr);
        chk("rnd_wr_data", mm_wr_data, m_wd);
      end
      if (e_rd) chk("rnd_rd_addr", mm_rd_addr, m_addr);
      m_prev_idle = !m_busy;
      done_now[0] = e_done && !m_owner;
      done_now[1] = e_done && m_owner;
      if (e_done) m_busy = 1'b0;
      for (int r = 0; r < 2; r++) begin
        if (done_last[r]) begin
          r_req[r] = 1'b0;
        end else if (!r_req[r] && $urandom_range(0, 2) == 0) begin
          r_req[r]  = 1'b1;
          r_we[r]   = 1'($urandom_range(0, 1));
          r_addr[r] = 16'h0080 + 16'($urandom_range(0, 15));
          r_wd[r]   = 16'($urandom);
        end
        done_last[r] = done_now[r];
        p_req[r] = r_req[r]; p_we[r] = r_we[r]; p_addr[r] = r_addr[r]; p_wd[r] = r_wd[r];
      end
      spi_req  = r_req[0]; spi_we  = r_we[0]; spi_addr  = r_addr[0]; spi_wdata  = r_wd[0];
      uart_req = r_req[1]; uart_we = r_we[1]; uart_addr = r_addr[1]; uart_wdata = r_wd[1];
    end
    drop_all();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
